// File: rtl/mix_round_sched.sv
// Serial sequencer for the 8-lane x 32-bit mixing datapath: one lane update per clock.
// Optional tail stage S7 is enabled by defining MIX_TAIL_EN (default build: 7 stages).
module mix_round_sched #(
  parameter int ROUNDS  = 1,
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ld_en,
  input  logic [2:0]         ld_idx,
  input  logic [31:0]        ld_data,
  input  logic [2:0]         rd_idx,
  output logic [31:0]        rd_data,
  output logic               busy,
  output logic               done,
  output logic [ROUND_W-1:0] round_cnt
);

  if (ROUNDS < 1) begin : g_chk_rounds
    $error("mix_round_sched: ROUNDS must be >= 1");
  end
  if (ROUND_W < 31 && (1 << ROUND_W) <= ROUNDS) begin : g_chk_round_w
    $error("mix_round_sched: ROUND_W too narrow for ROUNDS");
  end

`ifdef MIX_TAIL_EN
  localparam logic [2:0] LAST_STAGE = 3'd7;
`else
  localparam logic [2:0] LAST_STAGE = 3'd6;
`endif
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nx;
  logic [2:0]   stage;
  logic [2:0]   ptr;
  logic [31:0]  lane [8];
  logic [31:0]  cur, upd;
  logic [2:0]   im1, im2, ip1, ip2, ip3, ip4, ip5;
  logic         last_step;

  function automatic logic [31:0] m6(input logic [2:0] i);
    case (i)
      3'd0:    m6 = 32'd2;
      3'd1:    m6 = 32'd3;
      3'd2:    m6 = 32'd5;
      3'd3:    m6 = 32'd7;
      3'd4:    m6 = 32'd11;
      3'd5:    m6 = 32'd13;
      3'd6:    m6 = 32'd17;
      default: m6 = 32'd19;
    endcase
  endfunction

  function automatic logic [31:0] a6(input logic [2:0] i);
    case (i)
      3'd0:    a6 = 32'd3;
      3'd1:    a6 = 32'd5;
      3'd2:    a6 = 32'd7;
      3'd3:    a6 = 32'd11;
      3'd4:    a6 = 32'd13;
      3'd5:    a6 = 32'd17;
      3'd6:    a6 = 32'd19;
      default: a6 = 32'd23;
    endcase
  endfunction

`ifdef MIX_TAIL_EN
  function automatic logic [31:0] m7(input logic [2:0] i);
    case (i)
      3'd0:    m7 = 32'd2;
      3'd1:    m7 = 32'd3;
      3'd2:    m7 = 32'd3;
      3'd3:    m7 = 32'd3;
      3'd4:    m7 = 32'd5;
      3'd5:    m7 = 32'd13;
      3'd6:    m7 = 32'd35;
      default: m7 = 32'd87;
    endcase
  endfunction

  function automatic logic [31:0] a7(input logic [2:0] i);
    case (i)
      3'd0:    a7 = 32'd0;
      3'd1:    a7 = 32'd1;
      3'd2:    a7 = 32'd8;
      3'd3:    a7 = 32'd27;
      3'd4:    a7 = 32'd64;
      3'd5:    a7 = 32'd125;
      3'd6:    a7 = 32'd216;
      default: a7 = 32'd343;
    endcase
  endfunction
`endif

  // 3-bit neighbour indices wrap mod 8 on their own.
  assign im1 = ptr - 3'd1;
  assign im2 = ptr - 3'd2;
  assign ip1 = ptr + 3'd1;
  assign ip2 = ptr + 3'd2;
  assign ip3 = ptr + 3'd3;
  assign ip4 = ptr + 3'd4;
  assign ip5 = ptr + 3'd5;
  assign cur = lane[ptr];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    upd = cur;
    case (stage)
      3'd0: upd = cur + {29'd0, ptr};
      3'd1: upd = cur + lane[im1];
      3'd2: upd = cur + lane[ip1] - lane[ip5];
      3'd3: upd = cur ^ (lane[ip3] << 16);
      3'd4: upd = cur - (lane[ip2] >> 17) + (lane[ip4] >> 12);
      3'd5: upd = cur + lane[im1] - lane[im2];
      3'd6: upd = cur * m6(ptr) + a6(ptr);
`ifdef MIX_TAIL_EN
      3'd7: upd = cur * m7(ptr) + a7(ptr);
`endif
      default: upd = cur;
    endcase
  end

  assign last_step = (state == RUN) && (ptr == 3'd7) && (stage == LAST_STAGE)
                     && (round_cnt == LAST_ROUND);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage     <= '0;
      ptr       <= '0;
      round_cnt <= '0;
      // NOTE: the lane file is reset element by element because its reset value is part of the function.
      for (int i = 0; i < 8; i++) lane[i] <= 32'(i);
    end else if (state == RUN) begin
      lane[ptr] <= upd;
      ptr       <= ptr + 3'd1;
      if (ptr == 3'd7) begin
        if (stage == LAST_STAGE) begin
          stage     <= '0;
          round_cnt <= round_cnt + ROUND_W'(1);
        end else begin
          stage <= stage + 3'd1;
        end
      end
    end else begin
      if (ld_en) lane[ld_idx] <= ld_data;
      if (state == IDLE && start) begin
        round_cnt <= '0;
        stage     <= '0;
        ptr       <= '0;
      end
    end
  end

  assign rd_data = lane[rd_idx];
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_mix_round_sched.sv
// Self-checking bench: three instances (ROUNDS = 1, 2, 3) share the inputs and are checked
// against a sequential reference model of the stage equations. Honours MIX_TAIL_EN.
module tb_mix_round_sched;

`ifdef MIX_TAIL_EN
  localparam int NS = 8;
`else
  localparam int NS = 7;
`endif
  localparam int TOT_MAX = 8 * NS * 3;

  logic        clk = 1'b0;
  logic        rst, start, ld_en;
  logic [2:0]  ld_idx, rd_idx;
  logic [31:0] ld_data;
  logic [31:0] rd_data_o [3];
  logic        busy_o [3];
  logic        done_o [3];
  logic [7:0]  round_cnt_o [3];

  int errors = 0;
  int checks = 0;

  logic [31:0] seed_l [8];
  logic [31:0] exp_l  [3][8];
  logic [31:0] want   [3][8];

  logic [31:0] m6 [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  logic [31:0] a6 [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
  logic [31:0] m7 [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
  logic [31:0] a7 [8] = '{0, 1, 8, 27, 64, 125, 216, 343};

  always #10 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_round_sched #(.ROUNDS(g + 1), .ROUND_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ld_en     (ld_en),
      .ld_idx    (ld_idx),
      .ld_data   (ld_data),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data_o[g]),
      .busy      (busy_o[g]),
      .done      (done_o[g]),
      .round_cnt (round_cnt_o[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply each stage equation to lanes 0..7 in order, snapshot after each round.
  function automatic void compute_expected();
    logic [31:0] o [8];
    for (int i = 0; i < 8; i++) o[i] = seed_l[i];
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NS; s++) begin
        for (int i = 0; i < 8; i++) begin
          case (s)
            0: o[i] = o[i] + 32'(i);
            1: o[i] = o[i] + o[(i + 7) % 8];
            2: o[i] = o[i] + o[(i + 1) % 8] - o[(i + 5) % 8];
            3: o[i] = o[i] ^ (o[(i + 3) % 8] << 16);
            4: o[i] = o[i] - (o[(i + 2) % 8] >> 17) + (o[(i + 4) % 8] >> 12);
            5: o[i] = o[i] + o[(i + 7) % 8] - o[(i + 6) % 8];
            6: o[i] = o[i] * m6[i] + a6[i];
            default: o[i] = o[i] * m7[i] + a7[i];
          endcase
        end
      end
      for (int i = 0; i < 8; i++) exp_l[r][i] = o[i];
    end
  endfunction

  // Called at a negedge; eight 1 ns read steps finish before the next posedge.
  task automatic check_lanes(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      for (int g = 0; g < 3; g++)
        check($sformatf("%s r%0d lane%0d", tag, g + 1, i), rd_data_o[g], want[g][i]);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s r%0d busy", tag, g + 1), 32'(busy_o[g]), 32'd0);
      check($sformatf("%s r%0d done", tag, g + 1), 32'(done_o[g]), 32'd0);
      check($sformatf("%s r%0d round_cnt", tag, g + 1), 32'(round_cnt_o[g]), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_want_index();
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 8; i++) want[g][i] = 32'(i);
  endtask

  // Load seed_l (last load shares the start cycle), run to completion, check timing and lanes.
  task automatic run(input string tag, input bit timing, input bit inject);
    int dcnt [3];
    int tot;
    for (int g = 0; g < 3; g++) dcnt[g] = 0;
    compute_expected();
    for (int i = 0; i < 8; i++) begin
      ld_en   = 1'b1;
      ld_idx  = 3'(i);
      ld_data = seed_l[i];
      start   = (i == 7);
      @(negedge clk);
    end
    ld_en = 1'b0;
    start = 1'b0;
    for (int k = 0; k <= TOT_MAX + 1; k++) begin
      for (int g = 0; g < 3; g++) begin
        tot = 8 * NS * (g + 1);
        if (done_o[g]) begin
          dcnt[g]++;
          check($sformatf("%s r%0d round_cnt@done", tag, g + 1), 32'(round_cnt_o[g]), 32'(g + 1));
        end
        if (timing) begin
          check($sformatf("%s r%0d busy k=%0d", tag, g + 1, k), 32'(busy_o[g]), 32'(k < tot));
          check($sformatf("%s r%0d done k=%0d", tag, g + 1, k), 32'(done_o[g]), 32'(k == tot));
        end
      end
      if (inject && k == 10) begin
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_idx  = 3'd3;
        ld_data = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
        ld_en = 1'b0;
      end
      @(negedge clk);
    end
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s r%0d done pulses", tag, g + 1), 32'(dcnt[g]), 32'd1);
      for (int i = 0; i < 8; i++) want[g][i] = exp_l[g][i];
    end
    check_lanes(tag);
  endtask

  initial begin
    int dcnt;
    rst     = 1'b1;
    start   = 1'b0;
    ld_en   = 1'b0;
    ld_idx  = '0;
    ld_data = '0;
    rd_idx  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T1: reset state
    check_idle("t1");
    set_want_index();
    check_lanes("t1");

    // T2: stage-0 trace from reset values
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2 busy", 32'(busy_o[0]), 32'd1);
    repeat (8) @(negedge clk);
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 8; i++) want[g][i] = 32'(2 * i);
    check_lanes("t2");
    do_reset();

    // T2 variant: zero lanes, last load coincides with start
    for (int i = 0; i < 8; i++) begin
      ld_en   = 1'b1;
      ld_idx  = 3'(i);
      ld_data = 32'd0;
      start   = (i == 7);
      @(negedge clk);
    end
    ld_en = 1'b0;
    start = 1'b0;
    repeat (16) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      want[g][0] = 32'd7;  want[g][1] = 32'd8;  want[g][2] = 32'd10; want[g][3] = 32'd13;
      want[g][4] = 32'd17; want[g][5] = 32'd22; want[g][6] = 32'd28; want[g][7] = 32'd35;
    end
    check_lanes("t2v");
    do_reset();

    // T3: cycle-accurate busy/done for ROUNDS = 1, 2, 3
    for (int i = 0; i < 8; i++) seed_l[i] = 32'(i);
    run("t3", 1'b1, 1'b0);

    // T4: start and load during RUN are ignored
    for (int i = 0; i < 8; i++) seed_l[i] = $urandom;
    run("t4", 1'b0, 1'b1);

    // T5: reset mid-run
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("t5");
    set_want_index();
    check_lanes("t5");
    dcnt = 0;
    for (int k = 0; k < TOT_MAX; k++) begin
      for (int g = 0; g < 3; g++) if (done_o[g] || busy_o[g]) dcnt++;
      @(negedge clk);
    end
    check("t5 no activity after reset", 32'(dcnt), 32'd0);
    for (int i = 0; i < 8; i++) seed_l[i] = 32'(i);
    run("t5 rerun", 1'b0, 1'b0);

    // Boundary: all-ones seeds exercise every wrap
    for (int i = 0; i < 8; i++) seed_l[i] = 32'hFFFF_FFFF;
    run("ones", 1'b0, 1'b0);

    // T6: random golden compare
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 8; i++) seed_l[i] = $urandom;
      run($sformatf("t6 #%0d", n), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
